// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the 2:1 memory arbiter
// Purpose: FSM state and owner enums, default RAM base address, byte address to word index helper.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

  localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

  // Word index of a byte address; the subtraction wraps modulo 2^64 and is not range checked.
  function automatic logic [63:0] addr2idx(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - two-way priority picker with starvation override
// Purpose: dmem wins contention unless imem has lost STARVE_MAX contended grants in a row.
// Ports:
//   imem_valid  in   fetch request pending
//   dmem_valid  in   data request pending
//   starve_cnt  in   [3:0] consecutive contended dmem grants
//   grant       out  [1:0] one-hot grant, bit 0 = imem, bit 1 = dmem
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       imem_valid,
  input  logic       dmem_valid,
  input  logic [3:0] starve_cnt,
  output logic [1:0] grant
);

  logic starved;

  // The counter never passes STARVE_MAX; >= keeps the override sticky if it ever did.
  assign starved = (starve_cnt >= 4'(STARVE_MAX));

  always_comb begin
    grant = 2'b00;
    if (imem_valid && (!dmem_valid || starved)) begin
      grant = 2'b01;
    end else if (dmem_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arb_2to1.sv
// rtl/mem_arb_2to1.sv - shares one fixed-latency single-port RAM between fetch and data requesters
// Purpose: one transaction in flight; IDLE grants, WAIT covers RAM latency, CAPT latches read data,
//          RESP holds the response until the owner accepts it.
// Optional: define MEM_ARB_PERF_EN to add perf_imem_grants, perf_dmem_grants, perf_conflicts (32-bit, wrapping).
// Ports:
//   clk, reset                                   clock, synchronous active-high reset
//   imem_req_valid/ready/addr                    fetch request handshake and byte address
//   imem_resp_valid/ready/data                   fetch response, 32-bit instruction word
//   dmem_req_valid/ready/addr/wen/wdata/wmask    data request handshake and write fields
//   dmem_resp_valid/ready/rdata                  data response, 64-bit read data (0 for write acks)
//   ram_en/idx/wen/wdata/wmask                   RAM strobe and request fields, valid in the grant cycle
//   ram_rdata                                    RAM read data, valid RD_LAT cycles after ram_en
module mem_arb_2to1
  import mem_arb_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = MEM_BASE_DEFAULT,
  parameter int          RD_LAT     = 1,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req_valid,
  output logic        imem_req_ready,
  input  logic [63:0] imem_req_addr,
  output logic        imem_resp_valid,
  input  logic        imem_resp_ready,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic [63:0] dmem_req_addr,
  input  logic        dmem_req_wen,
  input  logic [63:0] dmem_req_wdata,
  input  logic [63:0] dmem_req_wmask,
  output logic        dmem_resp_valid,
  input  logic        dmem_resp_ready,
  output logic [63:0] dmem_resp_rdata,
  output logic        ram_en,
  output logic [63:0] ram_idx,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_imem_grants,
  output logic [31:0] perf_dmem_grants,
  output logic [31:0] perf_conflicts
`endif
);

  // WAIT is entered with RD_LAT-1 remaining cycles and leaves when one is left.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t      state_q, state_n;
  owner_t      owner_q;
  logic [2:0]  lat_q, lat_n;
  logic [63:0] resp_q;
  logic        half_q;
  logic        wr_q;
  logic [3:0]  starve_q;
  logic [1:0]  grant;
  logic        gnt_i, gnt_d;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .imem_valid (imem_req_valid),
    .dmem_valid (dmem_req_valid),
    .starve_cnt (starve_q),
    .grant      (grant)
  );

  always_comb begin
    state_n         = state_q;
    lat_n           = lat_q;
    gnt_i           = 1'b0;
    gnt_d           = 1'b0;
    ram_idx         = '0;
    ram_wen         = 1'b0;
    ram_wdata       = '0;
    ram_wmask       = '0;
    imem_resp_valid = (state_q == RESP) && (owner_q == OWN_IMEM);
    dmem_resp_valid = (state_q == RESP) && (owner_q == OWN_DMEM);
    case (state_q)
      IDLE: begin
        // Reset kills the strobe in the same cycle, not just on the next edge.
        gnt_i = grant[0] & ~reset;
        gnt_d = grant[1] & ~reset;
        if (gnt_d) begin
          ram_idx   = addr2idx(dmem_req_addr, MEM_BASE);
          ram_wen   = dmem_req_wen;
          ram_wdata = dmem_req_wdata;
          ram_wmask = dmem_req_wmask;
        end else if (gnt_i) begin
          ram_idx = addr2idx(imem_req_addr, MEM_BASE);
        end
        if (gnt_i || gnt_d) begin
          lat_n   = LAT_LOAD;
          state_n = (RD_LAT == 1) ? CAPT : WAIT;
        end
      end
      WAIT: begin
        if (lat_q <= 3'd1) begin
          state_n = CAPT;
        end else begin
          lat_n = lat_q - 3'd1;
        end
      end
      CAPT: state_n = RESP;
      RESP: begin
        if ((owner_q == OWN_IMEM && imem_resp_ready) || (owner_q == OWN_DMEM && dmem_resp_ready)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    imem_req_ready = gnt_i;
    dmem_req_ready = gnt_d;
    ram_en         = gnt_i | gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DMEM;
      lat_q    <= '0;
      resp_q   <= '0;
      half_q   <= 1'b0;
      wr_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q <= state_n;
      lat_q   <= lat_n;
      if (gnt_i) begin
        owner_q  <= OWN_IMEM;
        half_q   <= imem_req_addr[2];
        wr_q     <= 1'b0;
        starve_q <= '0;
      end
      if (gnt_d) begin
        owner_q <= OWN_DMEM;
        wr_q    <= dmem_req_wen;
        // Only grants that actually made imem wait count toward starvation.
        if (imem_req_valid && starve_q != 4'hF) begin
          starve_q <= starve_q + 4'd1;
        end
      end
      if (state_q == CAPT) begin
        resp_q <= wr_q ? '0 : ram_rdata;
      end
    end
  end

  assign dmem_resp_rdata = resp_q;
  assign imem_resp_data  = half_q ? resp_q[63:32] : resp_q[31:0];

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_imem_grants <= '0;
      perf_dmem_grants <= '0;
      perf_conflicts   <= '0;
    end else begin
      if (gnt_i) perf_imem_grants <= perf_imem_grants + 32'd1;
      if (gnt_d) perf_dmem_grants <= perf_dmem_grants + 32'd1;
      if (state_q == IDLE && imem_req_valid && dmem_req_valid) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb_2to1.sv
// tb/tb_mem_arb_2to1.sv - directed self-checking bench for mem_arb_2to1 with an RD_LAT RAM model
module tb_mem_arb_2to1;

  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid, dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_wdata, dmem_req_wmask;
  logic        dmem_resp_valid, dmem_resp_ready;
  logic [63:0] dmem_resp_rdata;
  logic        ram_en, ram_wen;
  logic [63:0] ram_idx, ram_wdata, ram_wmask, ram_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arb_2to1 #(.MEM_BASE(64'h8000_0000), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wen    (dmem_req_wen),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wmask  (dmem_req_wmask),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_ready (dmem_resp_ready),
    .dmem_resp_rdata (dmem_resp_rdata),
    .ram_en          (ram_en),
    .ram_idx         (ram_idx),
    .ram_wen         (ram_wen),
    .ram_wdata       (ram_wdata),
    .ram_wmask       (ram_wmask),
    .ram_rdata       (ram_rdata)
  );

  // RAM model: 16 words, read data appears RD_LAT cycles after ram_en, garbage otherwise.
  logic [63:0] mem  [16];
  logic [63:0] pipe [RD_LAT];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [63:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (ram_en && ram_wen)
      mem[ram_idx[3:0]] <= (mem[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    pipe[0] <= (ram_en && !ram_wen) ? mem[ram_idx[3:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One complete transaction with both resp_ready high; returns the response data.
  task automatic xact(input bit is_d, input logic [63:0] addr, input bit wen, input logic [63:0] wd,
                      input logic [63:0] wm, input logic [63:0] exp_idx, output logic [63:0] rd);
    int n;
    rd = '0;
    if (is_d) begin
      dmem_req_valid = 1'b1; dmem_req_addr = addr; dmem_req_wen = wen;
      dmem_req_wdata = wd; dmem_req_wmask = wm;
    end else begin
      imem_req_valid = 1'b1; imem_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(is_d ? dmem_req_ready : imem_req_ready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("grant_bound", 64'(n < 20), 64'd1);
    check("grant_ram_en", 64'(ram_en), 64'd1);
    check("grant_ram_idx", ram_idx, exp_idx);
    check("grant_ram_wen", 64'(ram_wen), 64'(wen));
    if (wen) begin
      check("grant_ram_wdata", ram_wdata, wd);
      check("grant_ram_wmask", ram_wmask, wm);
    end
    @(posedge clk); #1;
    dmem_req_valid = 1'b0; imem_req_valid = 1'b0;
    n = 1;
    while (!(is_d ? dmem_resp_valid : imem_resp_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("resp_latency", 64'(n), 64'(RD_LAT + 1));
    check("resp_other_idle", 64'(is_d ? imem_resp_valid : dmem_resp_valid), 64'd0);
    rd = is_d ? dmem_resp_rdata : {32'd0, imem_resp_data};
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {58'd0, imem_req_ready, dmem_req_ready, imem_resp_valid, dmem_resp_valid, ram_en, ram_wen}, 64'd0);
    check({tag, "_idx"}, ram_idx, 64'd0);
    check({tag, "_wdata"}, ram_wdata, 64'd0);
    check({tag, "_wmask"}, ram_wmask, 64'd0);
    check({tag, "_drdata"}, dmem_resp_rdata, 64'd0);
    check({tag, "_idata"}, {32'd0, imem_resp_data}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [63:0] r;
    logic        seen;
    int          n, cyc;
    logic        exp_ord [10];
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    imem_req_valid = 1'b0; imem_req_addr = '0; imem_resp_ready = 1'b1;
    dmem_req_valid = 1'b0; dmem_req_addr = '0; dmem_req_wen = 1'b0;
    dmem_req_wdata = '0; dmem_req_wmask = '0; dmem_resp_ready = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    preload(4'd0,  64'hAAAA_BBBB_CCCC_DDDD);
    preload(4'd1,  64'h5555_0000_0000_0000);
    preload(4'd2,  64'h0123_4567_89AB_CDEF);
    preload(4'd15, 64'hF00D_CAFE_1111_2222);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_state");

    // 1. single dmem read
    xact(1'b1, 64'h8000_0010, 1'b0, '0, '0, 64'd2, r);
    check("t1_rdata", r, 64'h0123_4567_89AB_CDEF);

    // 2. fetch half-select, addr[1:0] ignored
    xact(1'b0, 64'h8000_0004, 1'b0, '0, '0, 64'd0, r);
    check("t2_upper", r, 64'hAAAA_BBBB);
    xact(1'b0, 64'h8000_0000, 1'b0, '0, '0, 64'd0, r);
    check("t2_lower", r, 64'hCCCC_DDDD);
    xact(1'b0, 64'h8000_0007, 1'b0, '0, '0, 64'd0, r);
    check("t2_low_bits", r, 64'hAAAA_BBBB);

    // 3. masked write then read back; index wraps below MEM_BASE
    xact(1'b1, 64'h8000_0008, 1'b1, 64'h1234, 64'hFFFF, 64'd1, r);
    check("t3_write_ack", r, 64'd0);
    xact(1'b1, 64'h8000_0008, 1'b0, '0, '0, 64'd1, r);
    check("t3_readback", r, 64'h5555_0000_0000_1234);
    xact(1'b1, 64'h7FFF_FFF8, 1'b0, '0, '0, 64'h1FFF_FFFF_FFFF_FFFF, r);
    check("t3_wrap", r, 64'hF00D_CAFE_1111_2222);

    // 4. starvation order with both requesters continuously valid
    imem_req_addr = 64'h8000_0000; dmem_req_addr = 64'h8000_0010; dmem_req_wen = 1'b0;
    imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
    #1;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      if (imem_req_ready || dmem_req_ready) begin
        check("t4_order", 64'(dmem_req_ready), 64'(exp_ord[n]));
        check("t4_exclusive", 64'(imem_req_ready & dmem_req_ready), 64'd0);
        n++;
      end
      @(posedge clk); #2; cyc++;
    end
    check("t4_grant_count", 64'(n), 64'd10);
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 5. response backpressure
    dmem_resp_ready = 1'b0;
    dmem_req_valid = 1'b1; dmem_req_addr = 64'h8000_0010;
    #1;
    check("t5_grant", 64'(dmem_req_ready), 64'd1);
    @(posedge clk); #1;
    dmem_req_valid = 1'b0;
    imem_req_valid = 1'b1; imem_req_addr = 64'h8000_0004;
    n = 1;
    while (!dmem_resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("t5_latency", 64'(n), 64'(RD_LAT + 1));
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_valid", 64'(dmem_resp_valid), 64'd1);
      check("t5_hold_rdata", dmem_resp_rdata, 64'h0123_4567_89AB_CDEF);
      check("t5_no_ready", 64'({imem_req_ready, dmem_req_ready}), 64'd0);
      @(posedge clk); #1;
    end
    dmem_resp_ready = 1'b1;
    #1;
    check("t5_release_no_grant", 64'(imem_req_ready), 64'd0);
    @(posedge clk); #2;
    check("t5_grant_after_release", 64'(imem_req_ready), 64'd1);
    @(posedge clk); #1;
    imem_req_valid = 1'b0;
    n = 1;
    while (!imem_resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("t5_imem_data", {32'd0, imem_resp_data}, 64'hAAAA_BBBB);
    @(posedge clk); #1;

    // 6. reset while in WAIT
    dmem_req_valid = 1'b1; dmem_req_addr = 64'h8000_0008; dmem_req_wen = 1'b0;
    #1;
    check("t6_grant", 64'(dmem_req_ready), 64'd1);
    @(posedge clk); #1;
    dmem_req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_ram_en_in_reset", 64'(ram_en), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_after_reset");
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (imem_resp_valid || dmem_resp_valid) seen = 1'b1;
    end
    check("t6_no_resp", 64'(seen), 64'd0);
    xact(1'b1, 64'h8000_0010, 1'b0, '0, '0, 64'd2, r);
    check("t6_recover", r, 64'h0123_4567_89AB_CDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
